// File: rtl/jpeg_idct_drain.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_idct_drain
// Purpose  : Read-side drain for the IDCT output FIFO. Pops samples into one
//            of two 64-entry ping-pong banks. Optionally transposes each 8x8
//            block from column-major to raster order. Replays every complete
//            block on a valid/ready stream, with a last-of-block flag.
// Ports    : clk_i, rst_i (async, active-high), flush_i (sync frame abort)
//            fifo_data_i / fifo_valid_i / fifo_pop_o  - FIFO head interface
//            out_data_o / out_valid_o / out_ready_i / out_last_o - stream out
//            idle_o - no partial or complete block held
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_idct_drain #(
  parameter int WIDTH     = 8,
  parameter bit TRANSPOSE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_valid_i,
  output logic             fifo_pop_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             idle_o
);

  localparam logic [5:0] c_LAST_IDX = 6'd63;

  // Block storage: deliberately not reset, only the full flags qualify it.
  logic [WIDTH-1:0] r_mem [2][64];

  logic [1:0] r_full;
  logic       r_wr_bank;
  logic [5:0] r_wr_idx;
  logic       r_rd_bank;
  logic [5:0] r_rd_idx;

  logic       w_pop;
  logic       w_xfer;
  logic       w_valid;
  logic [5:0] w_wr_addr;
  logic [1:0] w_full_set;
  logic [1:0] w_full_clr;

  // Write address: column-major input k = col*8+row lands at row*8+col,
  // which is just the two 3-bit halves of the index swapped.
  generate
    if (TRANSPOSE) begin : g_addr_transpose
      assign w_wr_addr = {r_wr_idx[2:0], r_wr_idx[5:3]};
    end else begin : g_addr_passthru
      assign w_wr_addr = r_wr_idx;
    end
  endgenerate

  assign w_pop   = fifo_valid_i & ~r_full[r_wr_bank] & ~flush_i;
  assign w_valid = r_full[r_rd_bank];
  assign w_xfer  = w_valid & out_ready_i;

  // Set and clear can never hit the same bank: setting needs the write bank
  // empty, clearing needs the read bank full.
  always_comb begin
    w_full_set = 2'b00;
    w_full_clr = 2'b00;
    if (w_pop && (r_wr_idx == c_LAST_IDX)) begin
      w_full_set[r_wr_bank] = 1'b1;
    end
    if (w_xfer && (r_rd_idx == c_LAST_IDX)) begin
      w_full_clr[r_rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_mem[r_wr_bank][w_wr_addr] <= fifo_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_idx  <= 6'd0;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= 6'd0;
    end else if (flush_i) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_idx  <= 6'd0;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= 6'd0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      if (w_pop) begin
        r_wr_idx <= r_wr_idx + 6'd1;
        if (r_wr_idx == c_LAST_IDX) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_xfer) begin
        r_rd_idx <= r_rd_idx + 6'd1;
        if (r_rd_idx == c_LAST_IDX) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

  assign fifo_pop_o  = w_pop;
  assign out_valid_o = w_valid;
  assign out_data_o  = w_valid ? r_mem[r_rd_bank][r_rd_idx] : '0;
  assign out_last_o  = w_valid & (r_rd_idx == c_LAST_IDX);
  assign idle_o      = (r_full == 2'b00) & (r_wr_idx == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_jpeg_idct_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_idct_drain
// Purpose  : Self-checking bench for jpeg_idct_drain. Two instances (transpose
//            and pass-through) share one stimulus; a scoreboard per instance
//            holds the expected output order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_idct_drain;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic [7:0] fifo_data_i = 8'd0;
  logic       fifo_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;

  logic       pop_t, valid_t, last_t, idle_t;
  logic [7:0] data_t;
  logic       pop_p, valid_p, last_p, idle_p;
  logic [7:0] data_p;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_data = 1'b0;

  always #5 clk_i = ~clk_i;

  jpeg_idct_drain #(.WIDTH(8), .TRANSPOSE(1'b1)) dut_t (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_pop_o(pop_t),
    .out_data_o(data_t), .out_valid_o(valid_t), .out_ready_i(out_ready_i),
    .out_last_o(last_t), .idle_o(idle_t)
  );

  jpeg_idct_drain #(.WIDTH(8), .TRANSPOSE(1'b0)) dut_p (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_pop_o(pop_p),
    .out_data_o(data_p), .out_valid_o(valid_p), .out_ready_i(out_ready_i),
    .out_last_o(last_p), .idle_o(idle_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] q_t[$];
  logic [7:0] q_p[$];
  logic [7:0] part[64];
  int         part_n = 0;
  int         ocnt_t = 0;
  int         ocnt_p = 0;
  bit         hold_v = 1'b0;
  logic [7:0] hold_dt, hold_dp;
  logic       hold_l;

  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      q_t.delete();
      q_p.delete();
      part_n = 0;
      ocnt_t = 0;
      ocnt_p = 0;
      hold_v = 1'b0;
    end else begin
      chk("pop_agree", 32'(pop_t), 32'(pop_p));
      if (hold_v) begin
        chk("hold_valid", 32'(valid_t), 32'd1);
        chk("hold_data_t", 32'(data_t), 32'(hold_dt));
        chk("hold_data_p", 32'(data_p), 32'(hold_dp));
        chk("hold_last", 32'(last_t), 32'(hold_l));
      end
      if (!valid_t) begin
        chk("idle_data_zero", 32'(data_t), 32'd0);
        chk("idle_last_zero", 32'(last_t), 32'd0);
      end
      if (pop_t && fifo_valid_i) begin
        part[part_n] = fifo_data_i;
        part_n++;
        if (part_n == 64) begin
          for (int j = 0; j < 64; j++) q_p.push_back(part[j]);
          // raster output (row r, col c) comes from column-major input c*8+r
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              q_t.push_back(part[c*8+r]);
          part_n = 0;
        end
      end
      if (valid_t && out_ready_i) begin
        if (q_t.size() == 0) chk("unexpected_out_t", 32'(data_t), 32'hFFFF_FFFF);
        else begin
          chk("data_t", 32'(data_t), 32'(q_t.pop_front()));
          chk("last_t", 32'(last_t), 32'((ocnt_t % 64) == 63));
        end
        ocnt_t++;
      end
      if (valid_p && out_ready_i) begin
        if (q_p.size() == 0) chk("unexpected_out_p", 32'(data_p), 32'hFFFF_FFFF);
        else begin
          chk("data_p", 32'(data_p), 32'(q_p.pop_front()));
          chk("last_p", 32'(last_p), 32'((ocnt_p % 64) == 63));
        end
        ocnt_p++;
      end
      hold_v  = valid_t && !out_ready_i;
      hold_dt = data_t;
      hold_dp = data_p;
      hold_l  = last_t;
    end
  end

  // Drive n_in samples and/or wait for n_out transfers, one clock per step.
  task automatic run(input int n_in, input int n_out, input bit rv, input bit rr,
                     input bit rdy, input int budget,
                     output int pin, output int pout, output int cyc);
    bit popped;
    pin = 0; pout = 0; cyc = 0;
    while ((pin < n_in || pout < n_out) && cyc < budget) begin
      fifo_valid_i = (pin < n_in) && (rv ? (($urandom % 2) == 1) : 1'b1);
      out_ready_i  = rr ? (($urandom % 2) == 1) : rdy;
      @(negedge clk_i);
      popped = pop_t && fifo_valid_i;
      if (popped) pin++;
      if (valid_t && out_ready_i) pout++;
      cyc++;
      @(posedge clk_i);
      #1;
      if (popped) fifo_data_i = rnd_data ? 8'($urandom) : fifo_data_i + 8'd1;
    end
    fifo_valid_i = 1'b0;
  endtask

  int pin, pout, cyc, n;

  initial begin
    // ---- reset state ----
    fifo_valid_i = 1'b1;
    #7;
    chk("rst_valid", 32'(valid_t), 32'd0);
    chk("rst_last", 32'(last_t), 32'd0);
    chk("rst_data", 32'(data_t), 32'd0);
    chk("rst_idle_t", 32'(idle_t), 32'd1);
    chk("rst_idle_p", 32'(idle_p), 32'd1);
    fifo_valid_i = 1'b0;
    #5 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // ---- single block, samples 0..63 ----
    fifo_data_i = 8'd0;
    out_ready_i = 1'b1;
    run(63, 0, 1'b0, 1'b0, 1'b1, 100, pin, pout, cyc);
    chk("single_pops63", 32'(pin), 32'd63);
    fifo_valid_i = 1'b1;
    @(negedge clk_i);
    chk("single_pop64", 32'(pop_t), 32'd1);
    chk("single_not_yet_valid", 32'(valid_t), 32'd0);
    @(posedge clk_i); #1;
    fifo_valid_i = 1'b0;
    @(negedge clk_i);
    chk("latency_valid", 32'(valid_t), 32'd1);
    chk("first_out_t", 32'(data_t), 32'd0);
    @(posedge clk_i); #1;
    chk("second_out_t", 32'(data_t), 32'd8);
    run(0, 63, 1'b0, 1'b0, 1'b1, 100, pin, pout, cyc);
    chk("single_drain", 32'(pout), 32'd63);
    @(negedge clk_i);
    chk("single_idle", 32'(idle_t), 32'd1);
    chk("single_valid_low", 32'(valid_t), 32'd0);
    @(posedge clk_i); #1;

    // ---- back-pressure: 3 blocks against a stalled sink ----
    fifo_data_i = 8'd0;
    run(192, 0, 1'b0, 1'b0, 1'b0, 200, pin, pout, cyc);
    chk("bp_pops", 32'(pin), 32'd128);
    fifo_valid_i = 1'b1;
    @(negedge clk_i);
    chk("bp_pop_blocked", 32'(pop_t), 32'd0);
    chk("bp_not_idle", 32'(idle_t), 32'd0);
    @(posedge clk_i); #1;
    run(64, 192, 1'b0, 1'b0, 1'b1, 400, pin, pout, cyc);
    chk("bp_out_count", 32'(pout), 32'd192);
    chk("bp_no_gaps", 32'(cyc), 32'd192);

    // ---- streaming 4 blocks ----
    fifo_data_i = 8'd0;
    run(256, 256, 1'b0, 1'b0, 1'b1, 400, pin, pout, cyc);
    chk("stream_out_count", 32'(pout), 32'd256);
    chk("stream_cycles", 32'(cyc), 32'd320);

    // ---- random stalls, 20 blocks ----
    rnd_data = 1'b1;
    fifo_data_i = 8'($urandom);
    run(1280, 1280, 1'b1, 1'b1, 1'b1, 30000, pin, pout, cyc);
    chk("rand_pops", 32'(pin), 32'd1280);
    chk("rand_outs", 32'(pout), 32'd1280);

    // ---- flush after 1 block + 30 samples ----
    rnd_data = 1'b0;
    run(94, 0, 1'b0, 1'b0, 1'b0, 200, pin, pout, cyc);
    chk("flush_prefill", 32'(pin), 32'd94);
    fifo_valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_pop_low", 32'(pop_t), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    fifo_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_valid_low", 32'(valid_t), 32'd0);
    chk("flush_idle", 32'(idle_t), 32'd1);
    @(posedge clk_i); #1;
    run(64, 64, 1'b0, 1'b0, 1'b1, 300, pin, pout, cyc);
    chk("flush_fresh_out", 32'(pout), 32'd64);
    chk("flush_fresh_cycles", 32'(cyc), 32'd128);

    // ---- asynchronous reset mid-block ----
    rnd_data = 1'b1;
    n = 64 + $urandom_range(1, 62);
    run(n, 0, 1'b0, 1'b0, 1'b1, 300, pin, pout, cyc);
    chk("arst_prefill", 32'(pin), 32'(n));
    #1 rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_t), 32'd0);
    chk("arst_last", 32'(last_t), 32'd0);
    chk("arst_data", 32'(data_t), 32'd0);
    chk("arst_idle", 32'(idle_t), 32'd1);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    run(64, 64, 1'b0, 1'b0, 1'b1, 300, pin, pout, cyc);
    chk("arst_next_block", 32'(pout), 32'd64);

    // ---- everything expected was delivered ----
    repeat (3) @(posedge clk_i);
    #1;
    chk("sb_empty_t", 32'(q_t.size()), 32'd0);
    chk("sb_empty_p", 32'(q_p.size()), 32'd0);
    chk("final_idle", 32'(idle_t), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
